// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter (fifo_wr_arb, rr_pick).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_BURST  = 4;

    // Ceiling log2, never below 1 so index fields always have at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of req searching from start upward, wrapping.
// Latency: purely combinational.
// Backpressure: none; any=0 when req is empty.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0] pos;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        pos  = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, start} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
            if (!any && req[pos[IW-1:0]]) begin
                any                = 1'b1;
                pick[pos[IW-1:0]]  = 1'b1;
                idx                = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters; FIFO_ARB_BURST_EN adds burst ownership.
// Latency: zero-cycle grant, up to one write per cycle; state updates on the edge after a transfer.
// Backpressure: full forces gnt/wr_en low and freezes all state.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BURST  = DEF_BURST
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   din,
    input  logic                      full,
    output logic [N_REQ-1:0]          gnt,
    output logic                      wr_en,
    output logic [DATA_W-1:0]         wr_data,
    output logic [clog2(N_REQ)-1:0]   gnt_id,
    output logic                      busy
);

    localparam int IW = clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || BURST < 1 || BURST > 255) begin : g_bad_param
        $error("fifo_wr_arb: parameter out of range");
    end

    arb_state_t       state, state_nxt;
    logic [IW-1:0]    prio;
    logic [N_REQ-1:0] rr_gnt;
    logic [IW-1:0]    rr_idx;
    logic             rr_any;
    logic [IW-1:0]    win_idx;
    logic             xfer;

`ifdef FIFO_ARB_BURST_EN
    logic [IW-1:0]    owner;
    logic [7:0]       cnt;
    logic             cnt_last;
    assign cnt_last = (cnt == 8'(BURST - 1));
`endif

    function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
        return (i == IW'(N_REQ - 1)) ? '0 : i + IW'(1);
    endfunction

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .start (prio),
        .pick  (rr_gnt),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
`ifdef FIFO_ARB_BURST_EN
        if (!full) begin
            case (state)
                IDLE:    if (xfer && BURST > 1) state_nxt = OWN;
                OWN:     if (!req[owner] || cnt_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
`endif
    end

    // Output logic
    always_comb begin
        gnt     = '0;
        win_idx = rr_idx;
        busy    = 1'b0;
`ifdef FIFO_ARB_BURST_EN
        if (state == OWN) begin
            win_idx = owner;
            busy    = rst;
            if (rst && !full) gnt[owner] = req[owner];
        end else if (rst && !full && rr_any) begin
            gnt = rr_gnt;
        end
`else
        if (rst && !full && rr_any) gnt = rr_gnt;
`endif
        xfer    = |(req & gnt);
        wr_en   = xfer;
        wr_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) wr_data = wr_data | din[i*DATA_W +: DATA_W];
        end
    end

    // Priority, winner and burst bookkeeping; xfer already implies !full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prio   <= '0;
            gnt_id <= '0;
`ifdef FIFO_ARB_BURST_EN
            owner  <= '0;
            cnt    <= '0;
`endif
        end else if (xfer) begin
            gnt_id <= win_idx;
`ifdef FIFO_ARB_BURST_EN
            if (state == IDLE) begin
                if (BURST > 1) begin
                    owner <= win_idx;
                    cnt   <= 8'd1;
                end else begin
                    prio  <= inc_idx(win_idx);
                end
            end else if (cnt_last) begin
                cnt  <= '0;
                prio <= inc_idx(owner);
            end else begin
                cnt  <= cnt + 8'd1;
            end
`else
            prio   <= inc_idx(win_idx);
`endif
        end
`ifdef FIFO_ARB_BURST_EN
        else if (!full && state == OWN) begin
            // Owner withdrew its request: release the port early.
            cnt  <= '0;
            prio <= inc_idx(owner);
        end
`endif
    end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter that shares one FIFO write side among N_REQ requesters. It sits in front of the FIFO write pointer/memory. It takes the write-side full flag (the pointer's `stat` output) and drives the single write enable and write data. Grant priority rotates so that every requester holding a request is served within N_REQ transfers. An optional compile-time burst mode lets a winner keep the port for several consecutive writes.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `DATA_W`, 8: FIFO word width.
- `BURST`, 4: maximum consecutive transfers per grant in burst mode, 1..255. Ignored unless burst mode is compiled in.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `req`  in  N_REQ: per-requester write request (valid).
- `din`  in  N_REQ*DATA_W: packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- `full`  in  1: FIFO full flag from the write-side pointer.
- `gnt`  out  N_REQ: one-hot grant (ready); all zero when idle.
- `wr_en`  out  1: FIFO write enable, equal to |(req & gnt).
- `wr_data`  out  DATA_W: `din` slice of the granted requester; zero when `wr_en`=0.
- `gnt_id`  out  clog2(N_REQ): index of the current or last winner.
- `busy`  out  1: high while a burst owner holds the port. Always 0 without burst mode.

## Operation
- A transfer occurs in any cycle where req[i] & gnt[i]. The requester must hold `req` and its `din` slice stable until that cycle.
- `gnt` is combinational from registered state, `req` and `full`. At most one bit is set. It is never set for a requester whose `req` is low.
- `full`=1 forces `gnt`=0 and `wr_en`=0. All state, including the burst counter, holds unchanged. No write is ever issued while full.
- Priority register `prio` (clog2(N_REQ) bits) names the highest-priority index. The search order is prio, prio+1, …, wrapping modulo N_REQ.
- After each transfer by requester w, `prio` becomes (w+1) mod N_REQ, including the wrap from N_REQ-1 to 0. `prio` is unchanged in cycles with no transfer.
- FSM states are IDLE and OWN. Without burst mode the FSM stays in IDLE.
  - IDLE to OWN: a transfer by w with BURST>1. Load `owner`=w and `cnt`=1. `prio` does not advance.
  - OWN: `gnt` goes only to `owner`, regardless of other requests. Each transfer increments `cnt`.
  - OWN to IDLE when any of the following occurs:
    - a transfer makes `cnt` reach BURST;
    - req[owner] is low while `full`=0; no transfer occurs that cycle.
  - On exit to IDLE, `prio` becomes owner+1 mod N_REQ.
  - With BURST=1, a transfer leaves the FSM in IDLE, giving pure round-robin.
- `gnt_id` updates to the winner on every transfer and otherwise holds.
- Reset (`rst`=0 at a rising edge): `prio`=0, IDLE, `cnt`=0, `owner`=0, `gnt_id`=0. While `rst` is low, `gnt`, `wr_en` and `wr_data` are forced to 0 combinationally and `busy`=0.
- Reset mid-burst aborts the burst. The first grant after reset goes to the lowest-index active requester.

## Timing
- Zero-cycle arbitration: a request in cycle t can be granted and written in cycle t.
- Maximum throughput is one write per cycle.
- State changes take effect in the cycle after the edge at which the triggering transfer completes.
- Worst-case wait for a continuously requesting requester:
  - (N_REQ-1) transfers without burst mode;
  - (N_REQ-1)*BURST transfers with burst mode;
  - plus any cycles spent full.

## Configuration
- `FIFO_ARB_BURST_EN` defined: the OWN state, `cnt`/`owner` registers and the `busy` logic are compiled in, as described above.
- `FIFO_ARB_BURST_EN` undefined: single transfer per grant; `busy` is tied to 0; `BURST` has no effect.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state type `arb_state_t` (IDLE, OWN);
  - a `clog2` function;
  - the default `N_REQ`, `DATA_W` and `BURST` constants.
- Sub-module `rr_pick`: combinational rotating priority encoder. Inputs are a request vector and the start index. Outputs are a one-hot pick, the pick index and an any-valid flag. `fifo_wr_arb` instantiates it once.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with req=4'b1111 → `gnt`=0, `wr_en`=0, `gnt_id`=0. First cycle after release → gnt=4'b0001.
- Round-robin, burst off: req=4'b1111 held for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. `wr_data` matches each `din` slice.
- Wrap and skip: prio=3 with req=4'b0101 → gnt=4'b0001 (wrap to index 0), then gnt=4'b0100.
- Full stall: `full`=1 for 3 cycles with req=4'b0010 → no `wr_en`, `prio` unchanged. `full`=0 → gnt=4'b0010 in that cycle.
- Burst on, BURST=4: req=4'b0011 held → requester 0 gets 4 consecutive writes with `busy`=1, then requester 1 gets 4.
  - Drop req[0] after 2 writes → release; requester 1 is granted in the next cycle.
- Reset mid-burst: `rst`=0 during OWN with cnt=2 → IDLE, `busy`=0. After release with req=4'b1000 → gnt=4'b1000.
